// File: rtl/prescaler_period_meter_if.sv
// Bundles the measurement control inputs and the result outputs of prescaler_period_meter.
interface prescaler_period_meter_if #(
  parameter int unsigned CNT_W = 17
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period;
  logic [15:0]      div_est;
  logic             symmetric;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  modport master (
    output en, sig_in,
    input  high_cnt, low_cnt, period, div_est, symmetric, meas_valid, locked, timeout
  );

  modport slave (
    input  en, sig_in,
    output high_cnt, low_cnt, period, div_est, symmetric, meas_valid, locked, timeout
  );
endinterface

// File: rtl/prescaler_period_meter.sv
// Measures a slow square wave in clk cycles: high/low segment lengths, period, the recovered
// divide factor, symmetry and a lock indication once the period has been stable for a while.
module prescaler_period_meter #(
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned TIMEOUT = 65600,
  parameter int unsigned LOCK_N  = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  prescaler_period_meter_if.slave bus
);
  localparam int unsigned LW = $clog2(LOCK_N + 1);
  // Wide enough that (period>>1)-1 never wraps before the 16-bit saturation test.
  localparam int unsigned XW = CNT_W + 17;

  typedef enum logic [1:0] {StIdle, StAcquire, StRun} state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] seg_cnt_q, high_cnt_q, low_cnt_q;
  logic [CNT_W:0]   period_q;
  logic [15:0]      div_est_q;
  logic             symmetric_q, meas_valid_q, locked_q, timeout_q;
  logic             have_hi_q, have_lo_q;
  logic [LW-1:0]    lock_cnt_q;

  logic             rise, fall, edge_det, seg_to;
  logic [CNT_W-1:0] seg_inc;
  logic [CNT_W:0]   period_new, half;
  logic [XW-1:0]    dm1;
  logic [15:0]      div_new;
  logic [LW-1:0]    lock_new;

  // Edge detection, segment increment, and the candidate results for a closing rise.
  always_comb begin
    rise       = s2_q & ~s3_q;
    fall       = ~s2_q & s3_q;
    edge_det   = rise | fall;
    seg_inc    = (seg_cnt_q == {CNT_W{1'b1}}) ? seg_cnt_q : seg_cnt_q + CNT_W'(1);
    // An edge on the same cycle always wins over the timeout.
    seg_to     = (seg_cnt_q == CNT_W'(TIMEOUT)) && !edge_det;
    period_new = {1'b0, high_cnt_q} + {1'b0, seg_cnt_q};
    half       = period_new >> 1;
    dm1        = XW'(half) - XW'(1);
    if (half == '0) begin
      div_new = '0;
    end else if (dm1 > XW'(65535)) begin
      div_new = '1;
    end else begin
      div_new = dm1[15:0];
    end
    // lock_cnt_q == 0 means no previous period since acquisition.
    if ((lock_cnt_q != '0) && (period_new == period_q)) begin
      lock_new = (lock_cnt_q >= LW'(LOCK_N)) ? lock_cnt_q : lock_cnt_q + LW'(1);
    end else begin
      lock_new = LW'(1);
    end
  end

  // Input synchroniser, measurement FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      seg_cnt_q    <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      period_q     <= '0;
      div_est_q    <= '0;
      symmetric_q  <= 1'b0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      have_hi_q    <= 1'b0;
      have_lo_q    <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      s1_q         <= bus.sig_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      meas_valid_q <= 1'b0;
      if (!bus.en) begin
        // Disabling discards any in-flight segment; captured results are held.
        state_q    <= StIdle;
        seg_cnt_q  <= '0;
        locked_q   <= 1'b0;
        lock_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q   <= StAcquire;
            seg_cnt_q <= '0;
            timeout_q <= 1'b0;
            have_hi_q <= 1'b0;
            have_lo_q <= 1'b0;
          end
          StAcquire: begin
            if (edge_det) begin
              state_q   <= StRun;
              seg_cnt_q <= CNT_W'(1);
            end else if (seg_to) begin
              timeout_q  <= 1'b1;
              locked_q   <= 1'b0;
              lock_cnt_q <= '0;
              have_hi_q  <= 1'b0;
              have_lo_q  <= 1'b0;
              seg_cnt_q  <= '0;
            end else begin
              seg_cnt_q <= seg_inc;
            end
          end
          StRun: begin
            if (edge_det) begin
              seg_cnt_q <= CNT_W'(1);
              if (fall) begin
                high_cnt_q <= seg_cnt_q;
                have_hi_q  <= 1'b1;
              end
              if (rise) begin
                low_cnt_q <= seg_cnt_q;
                have_lo_q <= 1'b1;
                if (have_hi_q) begin
                  meas_valid_q <= 1'b1;
                  period_q     <= period_new;
                  div_est_q    <= div_new;
                  symmetric_q  <= (high_cnt_q == seg_cnt_q);
                  lock_cnt_q   <= lock_new;
                  locked_q     <= (lock_new >= LW'(LOCK_N));
                end
              end
            end else if (seg_to) begin
              state_q    <= StAcquire;
              timeout_q  <= 1'b1;
              locked_q   <= 1'b0;
              lock_cnt_q <= '0;
              have_hi_q  <= 1'b0;
              have_lo_q  <= 1'b0;
              seg_cnt_q  <= '0;
            end else begin
              seg_cnt_q <= seg_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.high_cnt   = high_cnt_q;
  assign bus.low_cnt    = low_cnt_q;
  assign bus.period     = period_q;
  assign bus.div_est    = div_est_q;
  assign bus.symmetric  = symmetric_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_prescaler_period_meter.sv
// Bench for prescaler_period_meter: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_prescaler_period_meter;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned LOCK_N  = 4;
  localparam int SEG_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prescaler_period_meter_if #(.CNT_W(CNT_W)) bus ();

  prescaler_period_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Square-wave source: level held gen_hi samples high, gen_lo samples low.
  bit   gen_on = 1'b0;
  int   gen_hi = 4;
  int   gen_lo = 4;
  int   gcnt = 0;
  logic sig_r = 1'b0;
  int   last_tog = 0;
  initial begin : gen
    forever begin
      @(posedge clk);
      #1;
      if (gen_on) begin
        gcnt++;
        if (gcnt >= (sig_r ? gen_hi : gen_lo)) begin
          sig_r      = ~sig_r;
          bus.sig_in = sig_r;
          gcnt       = 0;
          last_tog   = tcyc;
        end
      end
    end
  end

  // Reference model: edges as timestamps, lock as a window of recent periods.
  int   m_high, m_low, m_period, m_div;
  bit   m_sym, m_valid, m_locked, m_timeout;
  int   phase, anchor, mcyc;
  bit   seen_hi;
  logic hist [4];
  int   periods[$];

  function automatic int div_of(input int p);
    int d;
    if (p < 2) return 0;
    d = p / 2 - 1;
    if (d > 65535) d = 65535;
    return d;
  endfunction

  function automatic bit lock_of();
    if (periods.size() < LOCK_N) return 1'b0;
    foreach (periods[i]) if (periods[i] != periods[0]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin : model
    int len;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_high = 0; m_low = 0; m_period = 0; m_div = 0;
        m_sym = 0; m_valid = 0; m_locked = 0; m_timeout = 0;
        phase = 0; anchor = 0; mcyc = 0; seen_hi = 0;
        hist = '{default: 1'b0};
        periods.delete();
      end else begin
        mcyc++;
        hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = hist[3]; hist[3] = bus.sig_in;
        m_valid = 0;
        if (!bus.en) begin
          phase = 0; m_locked = 0; periods.delete();
        end else if (phase == 0) begin
          phase = 1; m_timeout = 0; seen_hi = 0; anchor = mcyc + 1;
        end else if (hist[1] != hist[0]) begin
          if (phase == 1) begin
            phase = 2; anchor = mcyc;
          end else begin
            len = mcyc - anchor;
            if (len > SEG_MAX) len = SEG_MAX;
            anchor = mcyc;
            if (!hist[1]) begin
              m_high = len; seen_hi = 1;
            end else begin
              if (seen_hi) begin
                m_period = m_high + len;
                m_div    = div_of(m_period);
                m_sym    = (m_high == len);
                m_valid  = 1;
                periods.push_back(m_period);
                if (periods.size() > LOCK_N) void'(periods.pop_front());
                m_locked = lock_of();
              end
              m_low = len;
            end
          end
        end else if (mcyc - anchor == TIMEOUT) begin
          m_timeout = 1; m_locked = 0; periods.delete();
          seen_hi = 0; phase = 1; anchor = mcyc + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus a meas_valid/lock monitor.
  int vcount = 0;
  int lock_at = -1;
  bit was_locked = 0;
  always @(negedge clk) begin
    chk("high_cnt", bus.high_cnt, m_high);
    chk("low_cnt", bus.low_cnt, m_low);
    chk("period", bus.period, m_period);
    chk("div_est", bus.div_est, m_div);
    chk("symmetric", bus.symmetric, m_sym);
    chk("meas_valid", bus.meas_valid, m_valid);
    chk("locked", bus.locked, m_locked);
    chk("timeout", bus.timeout, m_timeout);
    if (bus.meas_valid) vcount++;
    if (bus.locked && !was_locked && lock_at < 0) lock_at = vcount;
    was_locked = bus.locked;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic [31:0] dv, input logic [31:0] mv,
                     input logic [31:0] exp);
    chk({nm, "_dut"}, dv, exp);
    chk({nm, "_model"}, mv, exp);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (failures so far %0d)", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seen;
    int dly;
    bus.en = 1'b0;
    bus.sig_in = 1'b0;
    cyc(3);
    pin("rst_period", bus.period, m_period, 0);
    pin("rst_locked", bus.locked, m_locked, 0);
    rst_n = 1'b1;
    cyc(2);

    // D=3: toggle every 4 cycles
    vcount = 0; lock_at = -1;
    gen_hi = 4; gen_lo = 4; gen_on = 1'b1;
    bus.en = 1'b1;
    cyc(80);
    pin("t1_high", bus.high_cnt, m_high, 4);
    pin("t1_low", bus.low_cnt, m_low, 4);
    pin("t1_period", bus.period, m_period, 8);
    pin("t1_div", bus.div_est, m_div, 3);
    pin("t1_sym", bus.symmetric, m_sym, 1);
    pin("t1_locked", bus.locked, m_locked, 1);
    chk("t1_lock_on_valid", lock_at, 4);

    // D=0: toggle every cycle
    gen_hi = 1; gen_lo = 1;
    cyc(30);
    vcount = 0;
    cyc(20);
    chk("t2_valid_rate", vcount, 10);
    pin("t2_period", bus.period, m_period, 2);
    pin("t2_div", bus.div_est, m_div, 0);
    pin("t2_high", bus.high_cnt, m_high, 1);
    pin("t2_locked", bus.locked, m_locked, 1);

    // Locked at D=3, then switch to D=7
    gen_hi = 4; gen_lo = 4;
    cyc(60);
    pin("t3_pre_locked", bus.locked, m_locked, 1);
    gen_hi = 8; gen_lo = 8;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.locked) begin
        seen = 1;
        chk("t3_drop_with_valid", bus.meas_valid, 1);
        break;
      end
    end
    chk("t3_lock_dropped", seen, 1);
    cyc(150);
    pin("t3_period", bus.period, m_period, 16);
    pin("t3_div", bus.div_est, m_div, 7);
    pin("t3_relocked", bus.locked, m_locked, 1);

    // Stop toggling while locked
    gen_on = 1'b0;
    seen = 0;
    for (int i = 0; i < int'(TIMEOUT) + 50; i++) begin
      @(negedge clk);
      if (bus.timeout) begin
        seen = 1;
        break;
      end
    end
    chk("t4_timeout_seen", seen, 1);
    dly = tcyc - last_tog;
    // Timeout counts from the synchronised edge, three samples after the toggle.
    chk("t4_timeout_delay", dly, TIMEOUT + 3);
    chk("t4_unlocked", bus.locked, 0);
    cyc(TIMEOUT + 20);
    gen_on = 1'b1;
    cyc(60);
    pin("t4_sticky", bus.timeout, m_timeout, 1);
    bus.en = 1'b0;
    cyc(2);
    bus.en = 1'b1;
    cyc(2);
    pin("t4_cleared", bus.timeout, m_timeout, 0);

    // Asymmetric source high=5 low=3
    gen_hi = 5; gen_lo = 3;
    cyc(80);
    pin("t5_high", bus.high_cnt, m_high, 5);
    pin("t5_low", bus.low_cnt, m_low, 3);
    pin("t5_period", bus.period, m_period, 8);
    pin("t5_div", bus.div_est, m_div, 3);
    pin("t5_sym", bus.symmetric, m_sym, 0);
    // High segment of exactly the maximum length: edge wins over timeout
    gen_hi = 255; gen_lo = 3;
    cyc(800);
    pin("t5_hmax", bus.high_cnt, m_high, 255);
    pin("t5_pmax", bus.period, m_period, 258);
    pin("t5_dmax", bus.div_est, m_div, 128);
    pin("t5_no_to", bus.timeout, m_timeout, 0);
    gen_hi = 256;
    cyc(800);
    pin("t5_over_to", bus.timeout, m_timeout, 1);

    // en drop mid-segment, then reset mid-run
    gen_hi = 5; gen_lo = 3;
    bus.en = 1'b0;
    cyc(2);
    bus.en = 1'b1;
    cyc(80);
    pin("t6_locked", bus.locked, m_locked, 1);
    bus.en = 1'b0;
    cyc(1);
    vcount = 0;
    cyc(10);
    chk("t6_no_valid", vcount, 0);
    pin("t6_hold_high", bus.high_cnt, m_high, 5);
    pin("t6_hold_low", bus.low_cnt, m_low, 3);
    pin("t6_hold_period", bus.period, m_period, 8);
    pin("t6_idle_unlocked", bus.locked, m_locked, 0);
    bus.en = 1'b1;
    cyc(40);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_high", bus.high_cnt, 0);
    chk("t6_rst_period", bus.period, 0);
    chk("t6_rst_div", bus.div_est, 0);
    chk("t6_rst_locked", bus.locked, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
